// File: rtl/fb_cell_arbiter_pkg.sv
// Shared constants, FSM encodings and lane helpers for the framebuffer cell arbiter.
package fb_pkg;

    localparam int FB_CELL_COUNT = 1000;
    localparam int FB_IX_BITS    = 14;

    typedef logic [2:0] fb_state_t;

    localparam fb_state_t ST_IDLE      = 3'd0;
    localparam fb_state_t ST_DISP_RD   = 3'd1;
    localparam fb_state_t ST_DISP_WAIT = 3'd2;
    localparam fb_state_t ST_CPU_RD    = 3'd3;
    localparam fb_state_t ST_CPU_WAIT  = 3'd4;
    localparam fb_state_t ST_CPU_WR    = 3'd5;

    // Places a 4-bit word byte-enable into its lane of the 16-bit cell byte-enable.
    function automatic logic [15:0] fb_lane_mask(input logic [3:0] m, input logic [1:0] lane);
        logic [15:0] r;
        r = '0;
        r[{lane, 2'b00} +: 4] = m;
        return r;
    endfunction

    function automatic logic [127:0] fb_bit_mask(input logic [15:0] m);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[i*8 +: 8] = {8{m[i]}};
        end
        return r;
    endfunction

    function automatic logic [31:0] fb_sel_word(input logic [127:0] d, input logic [1:0] lane);
        return d[{lane, 5'b00000} +: 32];
    endfunction

endpackage

// File: rtl/fb_cell_arbiter_if.sv
// Display, CPU and cell-RAM signals of the arbiter; slave = arbiter side, master = environment side.
interface fb_cell_arbiter_if;
    import fb_pkg::*;

    logic [FB_IX_BITS-1:0] disp_ix;
    logic [127:0]          disp_data;
    logic                  disp_valid;
    logic                  cpu_req;
    logic                  cpu_we;
    logic [FB_IX_BITS+1:0] cpu_addr;
    logic [31:0]           cpu_wdata;
    logic [3:0]            cpu_wmask;
    logic                  cpu_ack;
    logic [31:0]           cpu_rdata;
    logic                  mem_en;
    logic                  mem_we;
    logic [FB_IX_BITS-1:0] mem_addr;
    logic [15:0]           mem_wmask;
    logic [127:0]          mem_wdata;
    logic [127:0]          mem_rdata;

    modport slave (
        input  disp_ix, cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wmask, mem_rdata,
        output disp_data, disp_valid, cpu_ack, cpu_rdata,
        output mem_en, mem_we, mem_addr, mem_wmask, mem_wdata
    );

    modport master (
        output disp_ix, cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wmask, mem_rdata,
        input  disp_data, disp_valid, cpu_ack, cpu_rdata,
        input  mem_en, mem_we, mem_addr, mem_wmask, mem_wdata
    );

endinterface

// File: rtl/fb_cell_arbiter.sv
// Shares the single-port cell RAM between display fetch and CPU; display valid 3 cycles after an index change.
// CPU read acks 3 cycles after grant, write 2; cpu_req is held until cpu_ack, starvation bounded by STARVE_MAX.
module fb_cell_arbiter
    import fb_pkg::*;
#(
    parameter int CELL_COUNT = FB_CELL_COUNT,
    parameter int IX_BITS    = FB_IX_BITS,
    parameter int STARVE_MAX = 4
) (
    input  logic             clock_i,
    input  logic             reset_ni,
    fb_cell_arbiter_if.slave bus
);

    localparam int                 SW         = $clog2(STARVE_MAX + 1);
    localparam logic [IX_BITS-1:0] CELL_LIM   = IX_BITS'(CELL_COUNT);
    localparam logic [SW-1:0]      STARVE_LIM = SW'(STARVE_MAX);

    fb_state_t          state_q, state_d;
    logic [IX_BITS-1:0] tag_q, tag_d;
    logic               tag_vld_q, tag_vld_d;
    logic [IX_BITS-1:0] fidx_q, fidx_d;
    logic [SW-1:0]      starve_q, starve_d;
    logic [127:0]       disp_data_q, disp_data_d;
    logic               cpu_ack_q, cpu_ack_d;
    logic [31:0]        cpu_rdata_q, cpu_rdata_d;
    logic               mem_en_q, mem_en_d;
    logic               mem_we_q, mem_we_d;
    logic [IX_BITS-1:0] mem_addr_q, mem_addr_d;
    logic [15:0]        mem_wmask_q, mem_wmask_d;
    logic [127:0]       mem_wdata_q, mem_wdata_d;

    logic [IX_BITS-1:0] cpu_ix;
    logic [1:0]         cpu_lane;
    logic               disp_pend;
    logic               cpu_pend;
    logic [127:0]       wr_bits;

    assign cpu_ix    = bus.cpu_addr[IX_BITS+1:2];
    assign cpu_lane  = bus.cpu_addr[1:0];
    assign disp_pend = !tag_vld_q || (bus.disp_ix != tag_q);
    // An ack cycle masks the still-high request so it is not granted twice.
    assign cpu_pend  = bus.cpu_req && !cpu_ack_q;
    assign wr_bits   = fb_bit_mask(fb_lane_mask(bus.cpu_wmask, cpu_lane));

    always_comb begin
        state_d     = state_q;
        tag_d       = tag_q;
        tag_vld_d   = tag_vld_q;
        fidx_d      = fidx_q;
        starve_d    = starve_q;
        disp_data_d = disp_data_q;
        cpu_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wmask_d = '0;
        mem_wdata_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (disp_pend && (!cpu_pend || (starve_q < STARVE_LIM))) begin
                    fidx_d = bus.disp_ix;
                    if (cpu_pend) begin
                        starve_d = starve_q + SW'(1);
                    end
                    // Out-of-range cells read as zero without a RAM cycle.
                    if (bus.disp_ix >= CELL_LIM) begin
                        tag_d       = bus.disp_ix;
                        tag_vld_d   = 1'b1;
                        disp_data_d = '0;
                    end else begin
                        state_d    = ST_DISP_RD;
                        mem_en_d   = 1'b1;
                        mem_addr_d = bus.disp_ix;
                    end
                end else if (cpu_pend) begin
                    starve_d = '0;
                    if (cpu_ix >= CELL_LIM) begin
                        cpu_ack_d   = 1'b1;
                        cpu_rdata_d = '0;
                    end else if (bus.cpu_we) begin
                        state_d     = ST_CPU_WR;
                        mem_en_d    = 1'b1;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = cpu_ix;
                        mem_wmask_d = fb_lane_mask(bus.cpu_wmask, cpu_lane);
                        mem_wdata_d = {4{bus.cpu_wdata}};
                    end else begin
                        state_d    = ST_CPU_RD;
                        mem_en_d   = 1'b1;
                        mem_addr_d = cpu_ix;
                    end
                end
            end
            ST_DISP_RD: state_d = ST_DISP_WAIT;
            ST_DISP_WAIT: begin
                disp_data_d = bus.mem_rdata;
                tag_d       = fidx_q;
                tag_vld_d   = 1'b1;
                state_d     = ST_IDLE;
            end
            ST_CPU_RD: state_d = ST_CPU_WAIT;
            ST_CPU_WAIT: begin
                cpu_rdata_d = fb_sel_word(bus.mem_rdata, cpu_lane);
                cpu_ack_d   = 1'b1;
                state_d     = ST_IDLE;
            end
            ST_CPU_WR: begin
                cpu_ack_d = 1'b1;
                state_d   = ST_IDLE;
                // Keep the held display cell coherent with the RAM copy.
                if (tag_vld_q && (tag_q == cpu_ix)) begin
                    disp_data_d = (disp_data_q & ~wr_bits) | ({4{bus.cpu_wdata}} & wr_bits);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= ST_IDLE;
            tag_q       <= '0;
            tag_vld_q   <= 1'b0;
            fidx_q      <= '0;
            starve_q    <= '0;
            disp_data_q <= '0;
            cpu_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wmask_q <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            tag_q       <= tag_d;
            tag_vld_q   <= tag_vld_d;
            fidx_q      <= fidx_d;
            starve_q    <= starve_d;
            disp_data_q <= disp_data_d;
            cpu_ack_q   <= cpu_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wmask_q <= mem_wmask_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign bus.disp_data  = disp_data_q;
    assign bus.disp_valid = tag_vld_q && (tag_q == bus.disp_ix);
    assign bus.cpu_ack    = cpu_ack_q;
    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.mem_en     = mem_en_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wmask  = mem_wmask_q;
    assign bus.mem_wdata  = mem_wdata_q;

endmodule
